ifid_latch: RTL and testbench

IFID_LATCH -- requirements
Module: ifid_latch

---
 rtl/ifid_latch.sv | 103 ++++++++++
 tb/tb_ifid_latch.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ifid_latch.sv
// IF/ID pipeline latch: holds the fetched instruction and its PC+4 for decode,
// with hold (IDdopause), squash (flush), bubble insertion and halt capture.
// Optional stall/flush event counters are built when IFID_PERF_EN is defined.
module ifid_latch #(
    parameter logic [31:0] NOP_WORD = 32'h0000_0000,
    parameter logic [5:0]  HALT_OP  = 6'h3F
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    input  logic [31:0] pc_plus4,
    input  logic        IDdopause,
    input  logic        flush,
    output logic [31:0] instr_out,
    output logic [31:0] npc_out,
    output logic        valid_out,
    output logic [4:0]  rs_out,
    output logic [4:0]  rt_out,
    output logic        halted
`ifdef IFID_PERF_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    typedef enum logic [1:0] {
        StEmpty,
        StValid,
        StHalted
    } state_e;

    state_e      state_q;
    logic [31:0] instr_q;
    logic [31:0] npc_q;

    // A halt only retires once it has actually been presented to decode.
    logic halt_pending;
    assign halt_pending = (state_q == StValid) && (instr_q[31:26] == HALT_OP);

    // Latch state and contents; priority is halted > flush > hold > halt retire > fetch > bubble.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= StEmpty;
            instr_q <= NOP_WORD;
            npc_q   <= 32'h0000_0000;
        end else if (state_q != StHalted) begin
            if (flush) begin
                state_q <= StEmpty;
                instr_q <= NOP_WORD;
                npc_q   <= 32'h0000_0000;
            end else if (!IDdopause) begin
                if (halt_pending) begin
                    // npc_q keeps the halt's PC+4 for debug visibility.
                    state_q <= StHalted;
                    instr_q <= NOP_WORD;
                end else if (ihit) begin
                    state_q <= StValid;
                    instr_q <= imemload;
                    npc_q   <= pc_plus4;
                end else begin
                    state_q <= StEmpty;
                    instr_q <= NOP_WORD;
                end
            end
        end
    end

    // Outputs decode registered state only; no input reaches an output combinationally.
    always_comb begin
        instr_out = instr_q;
        npc_out   = npc_q;
        valid_out = (state_q == StValid);
        halted    = (state_q == StHalted);
        rs_out    = valid_out ? instr_q[25:21] : 5'd0;
        rt_out    = valid_out ? instr_q[20:16] : 5'd0;
    end

`ifdef IFID_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    // Saturating event counters; frozen once halted.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt_q <= 32'h0000_0000;
            flush_cnt_q <= 32'h0000_0000;
        end else if (state_q != StHalted) begin
            if (IDdopause && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (flush && (flush_cnt_q != 32'hFFFF_FFFF)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_ifid_latch.sv
// Directed bench for ifid_latch: expected latch contents are queued when a step
// is driven and compared after the following rising edge.
module tb_ifid_latch;

    localparam logic [31:0] Nop = 32'h0000_0000;

    logic        CLK;
    logic        nRST;
    logic        ihit;
    logic [31:0] imemload;
    logic [31:0] pc_plus4;
    logic        IDdopause;
    logic        flush;
    logic [31:0] instr_out;
    logic [31:0] npc_out;
    logic        valid_out;
    logic [4:0]  rs_out;
    logic [4:0]  rt_out;
    logic        halted;
`ifdef IFID_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    ifid_latch dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .ihit     (ihit),
        .imemload (imemload),
        .pc_plus4 (pc_plus4),
        .IDdopause(IDdopause),
        .flush    (flush),
        .instr_out(instr_out),
        .npc_out  (npc_out),
        .valid_out(valid_out),
        .rs_out   (rs_out),
        .rt_out   (rt_out),
        .halted   (halted)
`ifdef IFID_PERF_EN
        ,
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        string       tag;
        logic [31:0] instr;
        logic [31:0] npc;
        logic        valid;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        hlt;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want)
        else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // Pop the oldest expectation and compare every output against it.
    task automatic check_head();
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard: got empty queue want entry");
            return;
        end
        e = sb.pop_front();
        chk({e.tag, ".instr"}, instr_out, e.instr);
        chk({e.tag, ".npc"}, npc_out, e.npc);
        chk({e.tag, ".valid"}, {31'd0, valid_out}, {31'd0, e.valid});
        chk({e.tag, ".rs"}, {27'd0, rs_out}, {27'd0, e.rs});
        chk({e.tag, ".rt"}, {27'd0, rt_out}, {27'd0, e.rt});
        chk({e.tag, ".halted"}, {31'd0, halted}, {31'd0, e.hlt});
    endtask

    // Drive one cycle of inputs (away from the edge), queue the expectation, check after the edge.
    task automatic step(input string tag, input logic h, input logic [31:0] w, input logic [31:0] pc,
                        input logic p, input logic f, input logic [31:0] ei,
                        input logic [31:0] en, input logic ev, input logic [4:0] ers,
                        input logic [4:0] ert, input logic eh);
        ihit      = h;
        imemload  = w;
        pc_plus4  = pc;
        IDdopause = p;
        flush     = f;
        sb.push_back('{tag, ei, en, ev, ers, ert, eh});
        @(posedge CLK);
        #1;
        check_head();
        @(negedge CLK);
    endtask

    // Reset pulse away from any clock edge; outputs must clear immediately.
    task automatic reset_pulse(input string tag);
        @(negedge CLK);
        #2;
        nRST = 1'b0;
        #1;
        sb.push_back('{tag, Nop, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0});
        check_head();
`ifdef IFID_PERF_EN
        chk({tag, ".stall_cnt"}, stall_cnt, 32'd0);
        chk({tag, ".flush_cnt"}, flush_cnt, 32'd0);
`endif
        ihit      = 1'b0;
        IDdopause = 1'b0;
        flush     = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    initial begin
        ihit      = 1'b0;
        imemload  = 32'h0;
        pc_plus4  = 32'h0;
        IDdopause = 1'b0;
        flush     = 1'b0;
        nRST      = 1'b1;
        #1;
        nRST = 1'b0;
        #2;
        sb.push_back('{"reset", Nop, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0});
        check_head();
        @(negedge CLK);
        nRST = 1'b1;

        // Basic capture with one-cycle latency.
        step("cap1", 1, 32'h2008_0005, 32'h4, 0, 0, 32'h2008_0005, 32'h4, 1, 5'd0, 5'd8, 0);
        step("cap2", 1, 32'h012A_4020, 32'h8, 0, 0, 32'h012A_4020, 32'h8, 1, 5'd9, 5'd10, 0);
        // Hold for three cycles while fetch keeps offering new words.
        for (int i = 0; i < 3; i++) begin
            step("hold", 1, $urandom | 32'h1, 32'h100 + i, 1, 0,
                 32'h012A_4020, 32'h8, 1, 5'd9, 5'd10, 0);
        end
`ifdef IFID_PERF_EN
        chk("stall_cnt3", stall_cnt, 32'd3);
`endif
        // Flush beats both hold and fetch.
        step("flush", 1, 32'h1234_5678, 32'hC, 1, 1, Nop, 32'h0, 0, 5'd0, 5'd0, 0);
`ifdef IFID_PERF_EN
        chk("flush_cnt1", flush_cnt, 32'd1);
`endif
        // Bubbles keep npc_out.
        step("cap3", 1, 32'h8C22_0010, 32'h10, 0, 0, 32'h8C22_0010, 32'h10, 1, 5'd1, 5'd2, 0);
        step("bub1", 0, 32'hDEAD_BEEF, 32'h14, 0, 0, Nop, 32'h10, 0, 5'd0, 5'd0, 0);
        step("bub2", 0, 32'hDEAD_BEEF, 32'h18, 0, 0, Nop, 32'h10, 0, 5'd0, 5'd0, 0);
        // Hold beats fetch even when empty.
        step("holdE", 1, 32'h2008_0005, 32'h1C, 1, 0, Nop, 32'h10, 0, 5'd0, 5'd0, 0);
        // Halt: presented once, retires on the next un-held edge.
        step("capH", 1, 32'hFC00_0000, 32'h20, 0, 0, 32'hFC00_0000, 32'h20, 1, 5'd0, 5'd0, 0);
        step("holdH", 1, 32'h2008_0005, 32'h24, 1, 0, 32'hFC00_0000, 32'h20, 1, 5'd0, 5'd0, 0);
        step("halt", 1, 32'h2008_0005, 32'h28, 0, 0, Nop, 32'h20, 0, 5'd0, 5'd0, 1);
        step("haltF", 1, 32'h2008_0005, 32'h2C, 0, 1, Nop, 32'h20, 0, 5'd0, 5'd0, 1);
        step("haltP", 1, 32'h2008_0005, 32'h30, 1, 0, Nop, 32'h20, 0, 5'd0, 5'd0, 1);
        reset_pulse("rstHalt");
        // Flush on the retiring edge cancels the halt.
        step("capH2", 1, 32'hFC00_0000, 32'h4, 0, 0, 32'hFC00_0000, 32'h4, 1, 5'd0, 5'd0, 0);
        step("cancel", 0, 32'h0, 32'h8, 0, 1, Nop, 32'h0, 0, 5'd0, 5'd0, 0);
        step("noHalt", 0, 32'h0, 32'hC, 0, 0, Nop, 32'h0, 0, 5'd0, 5'd0, 0);
        // Reset during a hold discards contents; first edge after release captures.
        step("cap4", 1, 32'h012A_4020, 32'h40, 0, 0, 32'h012A_4020, 32'h40, 1, 5'd9, 5'd10, 0);
        step("hold4", 1, 32'h1111_1111, 32'h44, 1, 0, 32'h012A_4020, 32'h40, 1, 5'd9, 5'd10, 0);
        reset_pulse("rstHold");
        step("cap5", 1, 32'h2008_0005, 32'h4, 0, 0, 32'h2008_0005, 32'h4, 1, 5'd0, 5'd8, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
